// File: rtl/dma_pcie_pkg.sv
// dma_pcie_pkg: shared PCIe CQ/CC codes, descriptor field positions and byte-enable helpers.
package dma_pcie_pkg;
  typedef enum logic [3:0] {REQ_MEM_RD = 4'h0, REQ_MEM_WR = 4'h1} req_type_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MEM_REQ, ST_CC_SEND, ST_DROP} state_e;
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam int CQ_DW_LO = 64;
  localparam int CQ_TYPE_LO = 75;
  localparam int CQ_RID_LO = 80;
  localparam int CQ_TAG_LO = 96;
  localparam int CQ_TC_LO = 121;
  localparam int CQ_ATTR_LO = 124;
  localparam int CQ_PL_LO = 128;
  localparam int CC_LA_LO = 0;
  localparam int CC_BC_LO = 16;
  localparam int CC_DW_LO = 32;
  localparam int CC_ST_LO = 43;
  localparam int CC_RID_LO = 48;
  localparam int CC_TAG_LO = 64;
  localparam int CC_TC_LO = 89;
  localparam int CC_ATTR_LO = 92;
  localparam int CC_DATA_LO = 96;
  localparam logic [7:0] CC_KEEP_1DW = 8'h0F;
  localparam logic [7:0] CC_KEEP_2DW = 8'h1F;
  localparam logic [7:0] CC_KEEP_UR = 8'h07;
  function automatic logic [1:0] be_lsb(input logic [3:0] be);
    return be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : be[3] ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [1:0] be_msb(input logic [3:0] be);
    return be[3] ? 2'd3 : be[2] ? 2'd2 : be[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pcie_be_decode.sv
// pcie_be_decode: byte enables to memory write strobes, lane select, completion lower address and byte count.
module pcie_be_decode
  import dma_pcie_pkg::*;
(
  input  logic [4:0]  i_addr,
  input  logic [3:0]  i_first_be,
  input  logic [3:0]  i_last_be,
  input  logic [10:0] i_dw_cnt,
  output logic [7:0]  o_we,
  output logic        o_lane,
  output logic [6:0]  o_lower_addr,
  output logic [12:0] o_byte_cnt
);
  logic w_one;
  logic w_two;
  logic [3:0] w_lbe;
  assign w_one = i_dw_cnt == 11'd1;
  assign w_two = i_dw_cnt == 11'd2;
  // a single-DW request has its last byte governed by firstBE
  assign w_lbe = w_one ? i_first_be : i_last_be;
  assign o_lane = i_addr[0];
  assign o_we = w_two ? {i_last_be, i_first_be} : o_lane ? {i_first_be, 4'h0} : {4'h0, i_first_be};
  assign o_lower_addr = {i_addr, be_lsb(i_first_be)};
  assign o_byte_cnt = (w_one && i_first_be == 4'h0) ? 13'd1 :
                      {i_dw_cnt, 2'b00} - 13'(be_lsb(i_first_be)) - 13'(2'd3 - be_msb(w_lbe));
endmodule

// File: rtl/pcie_cq_mem_bridge.sv
// pcie_cq_mem_bridge: services single-word MemRd/MemWr from the CQ stream on the DMA memory port, answering reads on CC.
module pcie_cq_mem_bridge
  import dma_pcie_pkg::*;
#(
  parameter int C_BUS_DATA_WIDTH = 256,
  parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 32,
  parameter int C_ADDR_WIDTH = 24,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_ACK_TIMEOUT = 1024
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [C_BUS_DATA_WIDTH-1:0] S_AXIS_CQ_TDATA,
  input  logic [84:0]                 S_AXIS_CQ_TUSER,
  input  logic                        S_AXIS_CQ_TLAST,
  input  logic [C_BUS_KEEP_WIDTH-1:0] S_AXIS_CQ_TKEEP,
  input  logic                        S_AXIS_CQ_TVALID,
  output logic [21:0]                 S_AXIS_CQ_TREADY,
  output logic [C_BUS_DATA_WIDTH-1:0] M_AXIS_CC_TDATA,
  output logic [32:0]                 M_AXIS_CC_TUSER,
  output logic                        M_AXIS_CC_TLAST,
  output logic [C_BUS_KEEP_WIDTH-1:0] M_AXIS_CC_TKEEP,
  output logic                        M_AXIS_CC_TVALID,
  input  logic [3:0]                  M_AXIS_CC_TREADY,
  output logic                        M_MEM_IFACE_EN,
  output logic [C_ADDR_WIDTH-1:0]     M_MEM_IFACE_ADDR,
  output logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DIN,
  output logic [7:0]                  M_MEM_IFACE_WE,
  input  logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DOUT,
  input  logic                        M_MEM_IFACE_ACK,
  output logic                        ERR_TIMEOUT
);
  localparam int CW = $clog2(C_ACK_TIMEOUT + 1);
  state_e r_state;
  state_e w_next;
  logic r_tready;
  logic r_en;
  logic r_cc_valid;
  logic r_err;
  logic [CW-1:0] r_cnt;
  logic [127:0] r_desc;
  logic [3:0] r_fbe;
  logic [3:0] r_lbe;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [C_DATA_WIDTH-1:0] r_din;
  logic [7:0] r_we;
  logic [C_BUS_DATA_WIDTH-1:0] r_cc_tdata;
  logic [C_BUS_KEEP_WIDTH-1:0] r_cc_tkeep;
  logic [127:0] w_desc;
  logic [3:0] w_fbe;
  logic [3:0] w_lbe;
  logic [3:0] w_type;
  logic [10:0] w_dw;
  logic w_rd;
  logic w_wr;
  logic w_ok;
  logic w_acc;
  logic w_ack;
  logic w_tmo;
  logic w_cc_hs;
  logic w_ur;
  logic [7:0] w_dec_we;
  logic w_dec_lane;
  logic [6:0] w_dec_la;
  logic [12:0] w_dec_bc;
  logic [31:0] w_dw0;
  logic [C_DATA_WIDTH-1:0] w_din;
  logic [C_DATA_WIDTH-1:0] w_rdata;
  logic [C_BUS_DATA_WIDTH-1:0] w_cc;
  logic [C_BUS_KEEP_WIDTH-1:0] w_keep;
  logic w_unused;
  assign w_unused = ^{S_AXIS_CQ_TKEEP, S_AXIS_CQ_TUSER[84:8], M_AXIS_CC_TREADY[3:1],
                      S_AXIS_CQ_TDATA[C_BUS_DATA_WIDTH-1:192], w_desc[1:0], w_desc[79],
                      w_desc[120:104], w_desc[127], w_desc[63:C_ADDR_WIDTH]};
  // in IDLE the decode looks at the live beat, afterwards at the latched request
  assign w_desc = r_state == ST_IDLE ? S_AXIS_CQ_TDATA[127:0] : r_desc;
  assign w_fbe = r_state == ST_IDLE ? S_AXIS_CQ_TUSER[3:0] : r_fbe;
  assign w_lbe = r_state == ST_IDLE ? S_AXIS_CQ_TUSER[7:4] : r_lbe;
  assign w_type = w_desc[CQ_TYPE_LO +: 4];
  assign w_dw = w_desc[CQ_DW_LO +: 11];
  assign w_rd = w_type == REQ_MEM_RD;
  assign w_wr = w_type == REQ_MEM_WR;
  assign w_ok = (w_rd || w_wr) && (w_dw == 11'd1 || (w_dw == 11'd2 && !w_desc[2]));
  assign w_acc = r_state == ST_IDLE && S_AXIS_CQ_TVALID && r_tready;
  assign w_ack = r_state == ST_MEM_REQ && M_MEM_IFACE_ACK;
  assign w_tmo = r_state == ST_MEM_REQ && !M_MEM_IFACE_ACK && r_cnt == CW'(C_ACK_TIMEOUT - 1);
  assign w_cc_hs = r_state == ST_CC_SEND && M_AXIS_CC_TREADY[0];
  assign w_ur = r_state == ST_IDLE;
  pcie_be_decode u_be_decode (
    .i_addr       (w_desc[6:2]),
    .i_first_be   (w_fbe),
    .i_last_be    (w_lbe),
    .i_dw_cnt     (w_dw),
    .o_we         (w_dec_we),
    .o_lane       (w_dec_lane),
    .o_lower_addr (w_dec_la),
    .o_byte_cnt   (w_dec_bc)
  );
  assign w_dw0 = S_AXIS_CQ_TDATA[CQ_PL_LO +: 32];
  assign w_din = w_dw == 11'd2 ? S_AXIS_CQ_TDATA[CQ_PL_LO +: 64] : w_dec_lane ? {w_dw0, 32'h0} : {32'h0, w_dw0};
  // an aborted read still completes, with all-ones data
  assign w_rdata = w_ur ? '0 : M_MEM_IFACE_ACK ? M_MEM_IFACE_DOUT : '1;
  assign w_keep = w_ur ? CC_KEEP_UR : w_dw == 11'd2 ? CC_KEEP_2DW : CC_KEEP_1DW;
  always_comb begin
    w_cc = '0;
    w_cc[CC_LA_LO +: 7] = w_dec_la;
    w_cc[CC_BC_LO +: 13] = w_dec_bc;
    w_cc[CC_DW_LO +: 11] = w_ur ? 11'd0 : w_dw;
    w_cc[CC_ST_LO +: 3] = w_ur ? CPL_UR : CPL_SC;
    w_cc[CC_RID_LO +: 16] = w_desc[CQ_RID_LO +: 16];
    w_cc[CC_TAG_LO +: 8] = w_desc[CQ_TAG_LO +: 8];
    w_cc[CC_TC_LO +: 3] = w_desc[CQ_TC_LO +: 3];
    w_cc[CC_ATTR_LO +: 3] = w_desc[CQ_ATTR_LO +: 3];
    w_cc[CC_DATA_LO +: 32] = w_dec_lane ? w_rdata[63:32] : w_rdata[31:0];
    w_cc[CC_DATA_LO + 32 +: 32] = w_dw == 11'd2 ? w_rdata[63:32] : 32'h0;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc) w_next = w_ok ? ST_MEM_REQ : w_rd ? ST_CC_SEND : S_AXIS_CQ_TLAST ? ST_IDLE : ST_DROP;
      ST_DROP:    if (S_AXIS_CQ_TVALID && S_AXIS_CQ_TLAST) w_next = ST_IDLE;
      ST_MEM_REQ: if (w_ack || w_tmo) w_next = w_rd ? ST_CC_SEND : ST_IDLE;
      ST_CC_SEND: if (w_cc_hs) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) r_state <= RST ? ST_IDLE : w_next;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tready <= 1'b0;
      r_en <= 1'b0;
      r_cc_valid <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_desc <= '0;
      r_fbe <= '0;
      r_lbe <= '0;
      r_addr <= '0;
      r_din <= '0;
      r_we <= '0;
      r_cc_tdata <= '0;
      r_cc_tkeep <= '0;
    end else begin
      r_tready <= w_next == ST_IDLE || w_next == ST_DROP;
      r_en <= w_next == ST_MEM_REQ;
      r_cc_valid <= w_next == ST_CC_SEND;
      r_err <= w_tmo;
      r_cnt <= r_state == ST_MEM_REQ ? r_cnt + 1'b1 : '0;
      if (w_acc && w_ok) begin
        r_desc <= S_AXIS_CQ_TDATA[127:0];
        r_fbe <= S_AXIS_CQ_TUSER[3:0];
        r_lbe <= S_AXIS_CQ_TUSER[7:4];
        r_addr <= {S_AXIS_CQ_TDATA[C_ADDR_WIDTH-1:3], 3'b000};
        r_din <= w_din;
        r_we <= w_wr ? w_dec_we : 8'h00;
      end
      if (w_next == ST_CC_SEND && r_state != ST_CC_SEND) begin
        r_cc_tdata <= w_cc;
        r_cc_tkeep <= w_keep;
      end
    end
  end
  assign S_AXIS_CQ_TREADY = {22{r_tready}};
  assign M_AXIS_CC_TDATA = r_cc_tdata;
  assign M_AXIS_CC_TUSER = '0;
  assign M_AXIS_CC_TLAST = r_cc_valid;
  assign M_AXIS_CC_TKEEP = r_cc_tkeep;
  assign M_AXIS_CC_TVALID = r_cc_valid;
  assign M_MEM_IFACE_EN = r_en;
  assign M_MEM_IFACE_ADDR = r_addr;
  assign M_MEM_IFACE_DIN = r_din;
  assign M_MEM_IFACE_WE = r_we;
  assign ERR_TIMEOUT = r_err;
endmodule

// File: tb/tb_pcie_cq_mem_bridge.sv
// tb_pcie_cq_mem_bridge: directed self-checking bench for the CQ-to-memory bridge.
module tb_pcie_cq_mem_bridge;
  localparam int TMO = 32;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [255:0] cq_tdata = '0;
  logic [84:0] cq_tuser = '0;
  logic cq_tlast = 1'b0;
  logic [7:0] cq_tkeep = '0;
  logic cq_tvalid = 1'b0;
  logic [21:0] cq_tready;
  logic [255:0] cc_tdata;
  logic [32:0] cc_tuser;
  logic cc_tlast;
  logic [7:0] cc_tkeep;
  logic cc_tvalid;
  logic [3:0] cc_tready = '0;
  logic mem_en;
  logic [23:0] mem_addr;
  logic [63:0] mem_din;
  logic [7:0] mem_we;
  logic [63:0] mem_dout = '0;
  logic mem_ack = 1'b0;
  logic err_tmo;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  pcie_cq_mem_bridge #(.C_ACK_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .S_AXIS_CQ_TDATA(cq_tdata), .S_AXIS_CQ_TUSER(cq_tuser), .S_AXIS_CQ_TLAST(cq_tlast),
    .S_AXIS_CQ_TKEEP(cq_tkeep), .S_AXIS_CQ_TVALID(cq_tvalid), .S_AXIS_CQ_TREADY(cq_tready),
    .M_AXIS_CC_TDATA(cc_tdata), .M_AXIS_CC_TUSER(cc_tuser), .M_AXIS_CC_TLAST(cc_tlast),
    .M_AXIS_CC_TKEEP(cc_tkeep), .M_AXIS_CC_TVALID(cc_tvalid), .M_AXIS_CC_TREADY(cc_tready),
    .M_MEM_IFACE_EN(mem_en), .M_MEM_IFACE_ADDR(mem_addr), .M_MEM_IFACE_DIN(mem_din),
    .M_MEM_IFACE_WE(mem_we), .M_MEM_IFACE_DOUT(mem_dout), .M_MEM_IFACE_ACK(mem_ack),
    .ERR_TIMEOUT(err_tmo)
  );
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] mk_cq(input logic [63:0] addr, input logic [10:0] dw, input logic [3:0] typ,
                                         input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                                         input logic [2:0] attr, input logic [63:0] pl);
    logic [255:0] d;
    d = '0;
    d[63:2] = addr[63:2];
    d[74:64] = dw;
    d[78:75] = typ;
    d[95:80] = rid;
    d[103:96] = tag;
    d[123:121] = tc;
    d[126:124] = attr;
    d[191:128] = pl;
    return d;
  endfunction
  task automatic send(input logic [255:0] d, input logic [3:0] fbe, input logic [3:0] lbe, input logic last);
    int n;
    n = 0;
    cq_tdata = d;
    cq_tuser = {77'h0, lbe, fbe};
    cq_tlast = last;
    cq_tvalid = 1'b1;
    while (!cq_tready[0] && n < 50) begin
      cyc();
      n++;
    end
    chk("cq_ready_wait", 256'(n < 50), 256'(1));
    cyc();
    cq_tvalid = 1'b0;
    cq_tlast = 1'b0;
  endtask
  initial begin
    logic [255:0] exp;
    int n;
    // reset state
    cyc(); cyc(); cyc();
    chk("rst_tready", cq_tready, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_cc_valid", cc_tvalid, 0);
    chk("rst_err", err_tmo, 0);
    chk("rst_cc_data", cc_tdata, 0);
    RST = 1'b0;
    cyc();
    chk("tready_after_rst", cq_tready, 22'h3FFFFF);
    // MemWr 1 DW upper lane
    send(mk_cq(64'h204, 11'd1, 4'h1, 16'h0, 8'h0, 3'd0, 3'd0, 64'h11223344), 4'hF, 4'h0, 1'b1);
    chk("wr1_en", mem_en, 1);
    chk("wr1_addr", mem_addr, 24'h000200);
    chk("wr1_we", mem_we, 8'hF0);
    chk("wr1_din_hi", mem_din[63:32], 32'h11223344);
    chk("wr1_tready_busy", cq_tready, 0);
    cyc(); cyc();
    mem_ack = 1'b1;
    chk("wr1_en_held", mem_en, 1);
    chk("wr1_addr_held", mem_addr, 24'h000200);
    cyc();
    mem_ack = 1'b0;
    chk("wr1_en_drop", mem_en, 0);
    chk("wr1_no_cc", cc_tvalid, 0);
    chk("wr1_tready_back", cq_tready, 22'h3FFFFF);
    // MemWr 2 DW
    send(mk_cq(64'h300, 11'd2, 4'h1, 16'h0, 8'h0, 3'd0, 3'd0, 64'h5A5A5A5A_A5A5A5A5), 4'hE, 4'h7, 1'b1);
    chk("wr2_we", mem_we, 8'h7E);
    chk("wr2_din", mem_din, 64'h5A5A5A5A_A5A5A5A5);
    chk("wr2_addr", mem_addr, 24'h000300);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("wr2_en_drop", mem_en, 0);
    // MemRd 2 DW, CC held off for 5 cycles
    send(mk_cq(64'h208, 11'd2, 4'h0, 16'h0100, 8'h2A, 3'd0, 3'd0, 64'h0), 4'hF, 4'hF, 1'b1);
    chk("rd2_en", mem_en, 1);
    chk("rd2_we", mem_we, 0);
    chk("rd2_addr", mem_addr, 24'h000208);
    mem_dout = 64'hAABBCCDD_01234567;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    mem_dout = '0;
    exp = '0;
    exp[6:0] = 7'h08;
    exp[28:16] = 13'd8;
    exp[42:32] = 11'd2;
    exp[63:48] = 16'h0100;
    exp[71:64] = 8'h2A;
    exp[127:96] = 32'h01234567;
    exp[159:128] = 32'hAABBCCDD;
    chk("rd2_en_drop", mem_en, 0);
    chk("rd2_cc_valid", cc_tvalid, 1);
    chk("rd2_cc_last", cc_tlast, 1);
    chk("rd2_cc_keep", cc_tkeep, 8'h1F);
    chk("rd2_cc_status", cc_tdata[45:43], 3'b000);
    chk("rd2_cc_data", cc_tdata, exp);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_cc_valid", cc_tvalid, 1);
      chk("hold_cc_data", cc_tdata, exp);
      chk("hold_cq_tready", cq_tready, 0);
    end
    cc_tready = 4'h1;
    cyc();
    chk("rd2_cc_done", cc_tvalid, 0);
    chk("rd2_tready_back", cq_tready, 22'h3FFFFF);
    // MemRd 1 DW, partial BE, upper lane, TC/attr echo
    send(mk_cq(64'h20C, 11'd1, 4'h0, 16'h1234, 8'h07, 3'd5, 3'd2, 64'h0), 4'hC, 4'h0, 1'b1);
    mem_dout = 64'hCAFEBABE_DEADBEEF;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    exp = '0;
    exp[6:0] = 7'h0E;
    exp[28:16] = 13'd2;
    exp[42:32] = 11'd1;
    exp[63:48] = 16'h1234;
    exp[71:64] = 8'h07;
    exp[91:89] = 3'd5;
    exp[94:92] = 3'd2;
    exp[127:96] = 32'hCAFEBABE;
    chk("rd1_cc_valid", cc_tvalid, 1);
    chk("rd1_cc_data", cc_tdata, exp);
    chk("rd1_cc_keep", cc_tkeep, 8'h0F);
    cyc();
    chk("rd1_cc_done", cc_tvalid, 0);
    // MemRd with no ACK
    send(mk_cq(64'h010, 11'd1, 4'h0, 16'h0, 8'h11, 3'd0, 3'd0, 64'h0), 4'hF, 4'h0, 1'b1);
    n = 0;
    while (mem_en && n < 200) begin
      chk("tmo_no_err_early", err_tmo, 0);
      n++;
      cyc();
    end
    chk("tmo_en_cycles", n, TMO);
    chk("tmo_err_pulse", err_tmo, 1);
    chk("tmo_cc_valid", cc_tvalid, 1);
    chk("tmo_cc_dw3", cc_tdata[127:96], 32'hFFFFFFFF);
    chk("tmo_cc_status", cc_tdata[45:43], 3'b000);
    chk("tmo_cc_dwcnt", cc_tdata[42:32], 11'd1);
    chk("tmo_cc_tag", cc_tdata[71:64], 8'h11);
    cyc();
    chk("tmo_err_single", err_tmo, 0);
    chk("tmo_cc_done", cc_tvalid, 0);
    // unsupported MemRd -> UR
    send(mk_cq(64'h100, 11'd4, 4'h0, 16'hBEEF, 8'h33, 3'd0, 3'd0, 64'h0), 4'hF, 4'hF, 1'b1);
    chk("ur_no_en", mem_en, 0);
    chk("ur_cc_valid", cc_tvalid, 1);
    chk("ur_status", cc_tdata[45:43], 3'b001);
    chk("ur_dwcnt", cc_tdata[42:32], 11'd0);
    chk("ur_keep", cc_tkeep, 8'h07);
    chk("ur_rid", cc_tdata[63:48], 16'hBEEF);
    cyc();
    chk("ur_cc_done", cc_tvalid, 0);
    // 3-beat MemWr with 16 DW is dropped
    send(mk_cq(64'h400, 11'd16, 4'h1, 16'h0, 8'h0, 3'd0, 3'd0, 64'h1), 4'hF, 4'hF, 1'b0);
    chk("drop_b1_tready", cq_tready, 22'h3FFFFF);
    chk("drop_b1_en", mem_en, 0);
    send(256'h2, 4'hF, 4'hF, 1'b0);
    chk("drop_b2_tready", cq_tready, 22'h3FFFFF);
    chk("drop_b2_en", mem_en, 0);
    send(256'h3, 4'hF, 4'hF, 1'b1);
    chk("drop_b3_tready", cq_tready, 22'h3FFFFF);
    chk("drop_b3_en", mem_en, 0);
    chk("drop_no_cc", cc_tvalid, 0);
    // reset while the memory access is pending
    send(mk_cq(64'h000, 11'd1, 4'h0, 16'h0, 8'h0, 3'd0, 3'd0, 64'h0), 4'h3, 4'h0, 1'b1);
    chk("rstm_en", mem_en, 1);
    RST = 1'b1;
    cyc();
    chk("rstm_en_drop", mem_en, 0);
    chk("rstm_tready", cq_tready, 0);
    RST = 1'b0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("rstm_tready_back", cq_tready, 22'h3FFFFF);
    cyc(); cyc();
    chk("rstm_no_cc", cc_tvalid, 0);
    chk("rstm_no_en", mem_en, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_cq_mem_bridge.md
Name: pcie_cq_mem_bridge

Overview:
Completer-side bridge that turns host BAR accesses arriving on the PCIe CQ AXI-Stream into single 64-bit transactions on the DMA memory interface (EN/ADDR/DIN/WE/DOUT/ACK). It returns read data as CC completions. It sits directly upstream of the DMA top's memory port and is the only path by which the CPU programs the engine table. Only MemRd and MemWr requests of 1–2 DW that stay inside one 64-bit word are serviced.

Parameters:
C_BUS_DATA_WIDTH, 256, CQ/CC data width; only 256 is supported.
C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/32, dword keep width.
C_ADDR_WIDTH, 24, memory interface byte-address width.
C_DATA_WIDTH, 64, memory interface data width; fixed at 64.
C_ACK_TIMEOUT, 1024, number of EN-high cycles before the access is aborted.

Ports:
CLK  in  1  clock
RST  in  1  reset
S_AXIS_CQ_TDATA  in  256  request descriptor (bits 127:0) plus payload (bits 255:128)
S_AXIS_CQ_TUSER  in  85  bits 3:0 = first BE, bits 7:4 = last BE
S_AXIS_CQ_TLAST  in  1  end of request
S_AXIS_CQ_TKEEP  in  8  dword keep; ignored
S_AXIS_CQ_TVALID  in  1  beat valid
S_AXIS_CQ_TREADY  out  22  all bits carry the same value
M_AXIS_CC_TDATA  out  256  completion descriptor (bits 95:0) plus data
M_AXIS_CC_TUSER  out  33  always 0
M_AXIS_CC_TLAST  out  1  always 1 while TVALID is high
M_AXIS_CC_TKEEP  out  8  dword keep
M_AXIS_CC_TVALID  out  1  completion valid
M_AXIS_CC_TREADY  in  4  only bit 0 is used
M_MEM_IFACE_EN  out  1  access request
M_MEM_IFACE_ADDR  out  C_ADDR_WIDTH  byte address, 8-byte aligned
M_MEM_IFACE_DIN  out  64  write data
M_MEM_IFACE_WE  out  8  byte write enables; 0 means read
M_MEM_IFACE_DOUT  in  64  read data, valid in the ACK cycle
M_MEM_IFACE_ACK  in  1  one-cycle completion strobe
ERR_TIMEOUT  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Single clock CLK. RST is synchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0, including TREADY. TREADY rises in the first cycle after RST falls.
- RST asserted in any state: return to IDLE; EN and CC_TVALID are low at the next edge; the pending request is discarded.
- CQ descriptor fields:
  - addr = bits 63:2
  - dword count = bits 74:64
  - req type = bits 78:75 (MemRd = 0000, MemWr = 0001)
  - requester ID = bits 95:80
  - tag = bits 103:96
  - TC = bits 123:121
  - attr = bits 126:124
- A request is supported when all hold: type is MemRd or MemWr; dword count is 1, or dword count is 2 with addr[2] = 0.
- FSM states: IDLE, MEM_REQ, CC_SEND, DROP.
- IDLE: TREADY = 1.
  - Supported request accepted at cycle T: latch the descriptor and payload; EN = 1 at T+1; go to MEM_REQ.
  - Unsupported MemRd: go to CC_SEND with status UR.
  - Anything else: discard the beat; go to DROP if TLAST = 0, otherwise stay in IDLE.
- DROP: TREADY = 1; consume beats until a TLAST beat is accepted, then go to IDLE. No other effects.
- MEM_REQ: TREADY = 0. EN, ADDR, DIN and WE are held stable until ACK.
  - ADDR = {addr[C_ADDR_WIDTH-1:3], 3'b000}.
  - WE for a write:
    - 1 DW with addr[2] = 0: {4'h0, firstBE}
    - 1 DW with addr[2] = 1: {firstBE, 4'h0}
    - 2 DW: {lastBE, firstBE}
  - DIN places payload DW0 (bits 159:128) in the lane selected by addr[2]; for 2 DW, DW1 (bits 191:160) goes in bits 63:32.
  - WE = 0 for a read.
  - ACK seen at cycle A: EN = 0 at A+1. A write goes to IDLE; a read captures DOUT and goes to CC_SEND.
  - Timeout: a counter increments on every EN-high cycle. If it reaches C_ACK_TIMEOUT without ACK, EN drops and ERR_TIMEOUT pulses. A write goes to IDLE; a read goes to CC_SEND with data 0xFFFFFFFF per DW and status SC.
  - An ACK arriving in the same cycle the count is reached wins.
- CC_SEND: CC_TVALID = 1 and TLAST = 1; the beat is held stable until TREADY[0]; the handshake cycle returns to IDLE.
- CC descriptor fields:
  - lower address (bits 6:0) = {addr[6:2], offset of the first enabled byte of firstBE}
  - byte count (bits 28:16) = 4*N minus leading zero bytes of firstBE minus trailing zero bytes of lastBE; for 1 DW this is the span of firstBE; firstBE = 0 gives 1
  - dword count (bits 42:32) = N for SC, 0 for UR
  - status (bits 45:43) = SC 000 or UR 001
  - requester ID (bits 63:48) and tag (bits 71:64) echo the request
  - TC (bits 91:89) and attr (bits 94:92) echo the request
  - all other fields are 0
- CC data:
  - DW3 (bits 127:96) = DOUT lane selected by addr[2]
  - for 2 DW, DW4 (bits 159:128) = DOUT[63:32]
- CC TKEEP: 0x0F for 1 DW, 0x1F for 2 DW, 0x07 for UR.

Decomposition:
- Shared package dma_pcie_pkg holds:
  - request-type codes
  - completion status codes
  - CQ/CC descriptor field bit positions
  - the CC TKEEP constants
- One combinational sub-module, pcie_be_decode, takes addr[6:2], firstBE, lastBE and dword count, and produces WE, lane select, lower address and byte count.

Test Plan:
- MemWr 1 DW, addr 0x204, firstBE 0xF, data 0x11223344, ACK 3 cycles after EN → EN at T+1, ADDR 0x000200, WE 0xF0, DIN[63:32] = 0x11223344; EN low the cycle after ACK; no CC beat.
- MemRd 2 DW, addr 0x208, tag 0x2A, requester ID 0x0100, BEs F/F, DOUT 0xAABBCCDD01234567 → CC lower address 0x08, byte count 8, dword count 2, status 0, DW3 0x01234567, DW4 0xAABBCCDD, TKEEP 0x1F.
- MemRd 1 DW, addr 0x20C, firstBE 0xC → lower address 0x0E, byte count 2, DW3 = DOUT[63:32], TKEEP 0x0F.
- MemRd with no ACK → EN high for exactly C_ACK_TIMEOUT cycles, one ERR_TIMEOUT pulse, CC DW3 0xFFFFFFFF.
- MemRd with dword count 4 → no EN, CC status 001, dword count 0, TKEEP 0x07. 3-beat MemWr with dword count 16 → dropped, TREADY high on all beats, no EN.
- CC_TREADY low for 5 cycles → CC beat stable and CQ TREADY low throughout. RST asserted during MEM_REQ → EN = 0 at the next edge, no CC emitted.
